// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: reserved tag, idle data value, opcodes and the
// default-width reservation-station entry layout.
package tomasulo_pkg;

    localparam logic [3:0]  FREE_REGISTER = 4'd0;
    localparam logic [15:0] NO_VALUE      = 16'hFFF0;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    typedef struct packed {
        logic        valid;
        logic [2:0]  op;
        logic [15:0] vj;
        logic [15:0] vk;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [0:0]  age;
    } rs_entry_t;

endpackage

// File: rtl/rs_oldest_ready_sel.sv
// Picks the ready entry with the largest age; equal ages resolve to the lowest index.
module rs_oldest_ready_sel
    import tomasulo_pkg::*;
#(
    parameter int unsigned N_RS  = 2,
    parameter int unsigned AGE_W = 1,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_RS-1:0]       ready,
    input  logic [N_RS*AGE_W-1:0] ages,
    output logic                  sel_valid,
    output logic [IDX_W-1:0]      sel_idx
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        // Strict compare keeps the earlier (lower) index on ties.
        for (int unsigned i = 0; i < N_RS; i++) begin
            if (ready[i] && (!sel_valid || (ages[i*AGE_W +: AGE_W] > best_age))) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = ages[i*AGE_W +: AGE_W];
            end
        end
    end

endmodule

// File: rtl/res_station_bank.sv
// Bank of N_RS reservation stations sharing one functional unit: dispatch, CDB
// snoop, oldest-ready selection and a registered valid/ready issue stage.
module res_station_bank
    import tomasulo_pkg::*;
#(
    parameter int unsigned N_RS     = 2,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned OP_W     = 3,
    parameter int unsigned TAG_BASE = 1,
    parameter logic [DATA_W-1:0] NO_VALUE = DATA_W'(tomasulo_pkg::NO_VALUE)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              Disp_Valid,
    output logic              Disp_Ready,
    input  logic [OP_W-1:0]   Disp_Opcode,
    input  logic [DATA_W-1:0] Disp_Vj,
    input  logic [DATA_W-1:0] Disp_Vk,
    input  logic [TAG_W-1:0]  Disp_Qj,
    input  logic [TAG_W-1:0]  Disp_Qk,
    output logic [TAG_W-1:0]  Disp_Tag,
    input  logic              CDB_Valid,
    input  logic [TAG_W-1:0]  CDB_Tag,
    input  logic [DATA_W-1:0] CDB_Data,
    output logic              Issue_Valid,
    input  logic              Issue_Ready,
    output logic [DATA_W-1:0] Issue_A,
    output logic [DATA_W-1:0] Issue_B,
    output logic [OP_W-1:0]   Issue_Op,
    output logic [TAG_W-1:0]  Issue_Tag,
    output logic [N_RS-1:0]   Busy_Vec
);

    localparam int unsigned AGE_W = (N_RS > 1) ? $clog2(N_RS) : 1;
    localparam int unsigned IDX_W = AGE_W;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(N_RS - 1);
    localparam logic [TAG_W-1:0] NO_TAG  = TAG_W'(FREE_REGISTER);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic [AGE_W-1:0]  age;
    } entry_t;

    entry_t entry_q [N_RS];
    entry_t entry_d [N_RS];
    entry_t new_entry;

    logic              issue_valid_q, issue_valid_d;
    logic [DATA_W-1:0] issue_a_q, issue_a_d;
    logic [DATA_W-1:0] issue_b_q, issue_b_d;
    logic [OP_W-1:0]   issue_op_q, issue_op_d;
    logic [TAG_W-1:0]  issue_tag_q, issue_tag_d;
    logic [IDX_W-1:0]  issue_idx_q, issue_idx_d;

    logic [N_RS-1:0]       held_by_issue;
    logic [N_RS-1:0]       ready_vec;
    logic [N_RS*AGE_W-1:0] age_flat;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic                  sel_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic                  dispatch_acc;
    logic                  cdb_hit;
    logic                  issue_load;

    // A slot stays reserved while the issue stage still carries its tag.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < N_RS; i++) begin
            held_by_issue[i]          = issue_valid_q && (issue_idx_q == IDX_W'(i));
            ready_vec[i]              = entry_q[i].valid && (entry_q[i].qj == NO_TAG)
                                        && (entry_q[i].qk == NO_TAG);
            age_flat[i*AGE_W +: AGE_W] = entry_q[i].age;
            Busy_Vec[i]               = entry_q[i].valid || held_by_issue[i];
            if (!Busy_Vec[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    rs_oldest_ready_sel #(
        .N_RS  (N_RS),
        .AGE_W (AGE_W),
        .IDX_W (IDX_W)
    ) u_sel (
        .ready     (ready_vec),
        .ages      (age_flat),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx)
    );

    assign Disp_Ready   = free_found;
    assign Disp_Tag     = free_found ? TAG_W'(TAG_BASE + 32'(free_idx)) : NO_TAG;
    assign dispatch_acc = Disp_Valid && free_found;
    assign cdb_hit      = CDB_Valid && (CDB_Tag != NO_TAG);
    assign issue_load   = !issue_valid_q || Issue_Ready;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.op    = Disp_Opcode;
        new_entry.vj    = Disp_Vj;
        new_entry.vk    = Disp_Vk;
        new_entry.qj    = Disp_Qj;
        new_entry.qk    = Disp_Qk;
        if (cdb_hit && (CDB_Tag == Disp_Qj)) begin
            new_entry.vj = CDB_Data;
            new_entry.qj = NO_TAG;
        end
        if (cdb_hit && (CDB_Tag == Disp_Qk)) begin
            new_entry.vk = CDB_Data;
            new_entry.qk = NO_TAG;
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_op_d    = issue_op_q;
        issue_tag_d   = issue_tag_q;
        issue_idx_d   = issue_idx_q;
        for (int unsigned i = 0; i < N_RS; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].valid) begin
                if (cdb_hit && (entry_q[i].qj == CDB_Tag)) begin
                    entry_d[i].vj = CDB_Data;
                    entry_d[i].qj = NO_TAG;
                end
                if (cdb_hit && (entry_q[i].qk == CDB_Tag)) begin
                    entry_d[i].vk = CDB_Data;
                    entry_d[i].qk = NO_TAG;
                end
                if (dispatch_acc && (entry_q[i].age != AGE_MAX)) begin
                    entry_d[i].age = entry_q[i].age + 1'b1;
                end
            end
        end
        if (issue_load) begin
            issue_valid_d = sel_valid;
            if (sel_valid) begin
                issue_a_d   = entry_q[sel_idx].vj;
                issue_b_d   = entry_q[sel_idx].vk;
                issue_op_d  = entry_q[sel_idx].op;
                issue_tag_d = TAG_W'(TAG_BASE + 32'(sel_idx));
                issue_idx_d = sel_idx;
                entry_d[sel_idx].valid = 1'b0;
            end else begin
                issue_a_d   = '0;
                issue_b_d   = '0;
                issue_op_d  = '0;
                issue_tag_d = '0;
                issue_idx_d = '0;
            end
        end
        if (dispatch_acc) begin
            entry_d[free_idx] = new_entry;
        end
        if (Flush) begin
            for (int unsigned i = 0; i < N_RS; i++) begin
                entry_d[i] = '0;
            end
            issue_valid_d = 1'b0;
            issue_a_d     = '0;
            issue_b_d     = '0;
            issue_op_d    = '0;
            issue_tag_d   = '0;
            issue_idx_d   = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < N_RS; i++) begin
                entry_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_op_q    <= '0;
            issue_tag_q   <= '0;
            issue_idx_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < N_RS; i++) begin
                entry_q[i] <= entry_d[i];
            end
            issue_valid_q <= issue_valid_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_op_q    <= issue_op_d;
            issue_tag_q   <= issue_tag_d;
            issue_idx_q   <= issue_idx_d;
        end
    end

    assign Issue_Valid = issue_valid_q;
    assign Issue_A     = issue_valid_q ? issue_a_q : NO_VALUE;
    assign Issue_B     = issue_valid_q ? issue_b_q : NO_VALUE;
    assign Issue_Op    = issue_op_q;
    assign Issue_Tag   = issue_tag_q;

endmodule

// File: tb/tb_res_station_bank.sv
// Scoreboard bench for res_station_bank (N_RS=4): directed dispatch/CDB/flush/reset
// scenarios with a negedge monitor comparing every completed issue transfer.
module tb_res_station_bank;

    logic        Clock;
    logic        Reset;
    logic        Flush;
    logic        Disp_Valid;
    logic        Disp_Ready;
    logic [2:0]  Disp_Opcode;
    logic [15:0] Disp_Vj, Disp_Vk;
    logic [3:0]  Disp_Qj, Disp_Qk;
    logic [3:0]  Disp_Tag;
    logic        CDB_Valid;
    logic [3:0]  CDB_Tag;
    logic [15:0] CDB_Data;
    logic        Issue_Valid;
    logic        Issue_Ready;
    logic [15:0] Issue_A, Issue_B;
    logic [2:0]  Issue_Op;
    logic [3:0]  Issue_Tag;
    logic [3:0]  Busy_Vec;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    res_station_bank #(
        .N_RS     (4),
        .DATA_W   (16),
        .TAG_W    (4),
        .OP_W     (3),
        .TAG_BASE (1),
        .NO_VALUE (16'hFFF0)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Flush       (Flush),
        .Disp_Valid  (Disp_Valid),
        .Disp_Ready  (Disp_Ready),
        .Disp_Opcode (Disp_Opcode),
        .Disp_Vj     (Disp_Vj),
        .Disp_Vk     (Disp_Vk),
        .Disp_Qj     (Disp_Qj),
        .Disp_Qk     (Disp_Qk),
        .Disp_Tag    (Disp_Tag),
        .CDB_Valid   (CDB_Valid),
        .CDB_Tag     (CDB_Tag),
        .CDB_Data    (CDB_Data),
        .Issue_Valid (Issue_Valid),
        .Issue_Ready (Issue_Ready),
        .Issue_A     (Issue_A),
        .Issue_B     (Issue_B),
        .Issue_Op    (Issue_Op),
        .Issue_Tag   (Issue_Tag),
        .Busy_Vec    (Busy_Vec)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive_disp(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                              input logic [3:0] qj, input logic [3:0] qk);
        Disp_Valid  = 1'b1;
        Disp_Opcode = op;
        Disp_Vj     = vj;
        Disp_Vk     = vk;
        Disp_Qj     = qj;
        Disp_Qk     = qk;
    endtask

    task automatic idle_disp();
        Disp_Valid = 1'b0;
        Disp_Qj    = '0;
        Disp_Qk    = '0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] op, input logic [3:0] tag);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.tag = tag;
        sb.push_back(e);
    endtask

    // Completed transfers are compared in order against the queued expectations.
    always @(negedge Clock) begin
        if (Reset && Issue_Valid && Issue_Ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_issue", {28'd0, Issue_Tag}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_a",   {16'd0, Issue_A},   {16'd0, mon_e.a});
                chk("sb_b",   {16'd0, Issue_B},   {16'd0, mon_e.b});
                chk("sb_op",  {29'd0, Issue_Op},  {29'd0, mon_e.op});
                chk("sb_tag", {28'd0, Issue_Tag}, {28'd0, mon_e.tag});
            end
        end
    end

    initial begin
        Reset = 1'b0; Flush = 1'b0; Issue_Ready = 1'b0;
        Disp_Valid = 1'b0; Disp_Opcode = '0; Disp_Vj = '0; Disp_Vk = '0;
        Disp_Qj = '0; Disp_Qk = '0;
        CDB_Valid = 1'b0; CDB_Tag = '0; CDB_Data = '0;
        #2;
        chk("reset_issue_valid", Issue_Valid, 0);
        chk("reset_issue_a", Issue_A, 32'hFFF0);
        chk("reset_busy", Busy_Vec, 0);
        chk("reset_disp_ready", Disp_Ready, 1);
        chk("reset_disp_tag", Disp_Tag, 1);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        tick();

        // Fully ready dispatch issues on the following edge.
        Issue_Ready = 1'b1;
        drive_disp(3'd1, 16'd3, 16'd4, 4'd0, 4'd0);
        chk("t2_disp_tag", Disp_Tag, 1);
        push_exp(16'd3, 16'd4, 3'd1, 4'd1);
        tick();
        idle_disp();
        chk("t2_valid_early", Issue_Valid, 0);
        chk("t2_busy", Busy_Vec, 4'b0001);
        tick();
        chk("t2_valid", Issue_Valid, 1);
        chk("t2_busy_hold", Busy_Vec, 4'b0001);
        tick();
        chk("t2_drained", Issue_Valid, 0);
        chk("t2_busy_clear", Busy_Vec, 0);

        // Operand captured from the CDB two cycles after dispatch.
        drive_disp(3'd2, 16'd0, 16'd8, 4'd5, 4'd0);
        tick();
        idle_disp();
        tick();
        CDB_Valid = 1'b1; CDB_Tag = 4'd5; CDB_Data = 16'h0007;
        tick();
        CDB_Valid = 1'b0;
        chk("t3_valid_early", Issue_Valid, 0);
        push_exp(16'h0007, 16'd8, 3'd2, 4'd1);
        tick();
        chk("t3_valid", Issue_Valid, 1);
        chk("t3_a", Issue_A, 16'h0007);
        tick();
        chk("t3_drained", Issue_Valid, 0);

        // Same-cycle bypass on Qk.
        drive_disp(3'd3, 16'd2, 16'd0, 4'd0, 4'd5);
        CDB_Valid = 1'b1; CDB_Tag = 4'd5; CDB_Data = 16'h0009;
        chk("t4_disp_tag", Disp_Tag, 1);
        push_exp(16'd2, 16'h0009, 3'd3, 4'd1);
        tick();
        idle_disp();
        CDB_Valid = 1'b0;
        tick();
        chk("t4_valid", Issue_Valid, 1);
        chk("t4_b", Issue_B, 16'h0009);
        tick();
        chk("t4_drained", Issue_Valid, 0);

        // Fill the bank; entries 0 and 2 wait on tag 6, entries 1 and 3 on tag 7.
        Issue_Ready = 1'b0;
        drive_disp(3'd4, 16'd0, 16'h0010, 4'd6, 4'd0);
        chk("t5_tag_e0", Disp_Tag, 1);
        tick();
        drive_disp(3'd5, 16'd0, 16'h0021, 4'd7, 4'd0);
        chk("t5_tag_e1", Disp_Tag, 2);
        tick();
        drive_disp(3'd6, 16'h0032, 16'd0, 4'd0, 4'd6);
        chk("t5_tag_e2", Disp_Tag, 3);
        tick();
        drive_disp(3'd7, 16'd0, 16'h0043, 4'd7, 4'd0);
        chk("t5_tag_e3", Disp_Tag, 4);
        tick();
        idle_disp();
        chk("t5_full_ready", Disp_Ready, 0);
        chk("t5_full_tag", Disp_Tag, 0);
        chk("t5_full_busy", Busy_Vec, 4'b1111);
        drive_disp(3'd1, 16'd1, 16'd1, 4'd0, 4'd0);
        tick();
        idle_disp();
        chk("t5_drop_busy", Busy_Vec, 4'b1111);
        chk("t5_drop_valid", Issue_Valid, 0);
        CDB_Valid = 1'b1; CDB_Tag = 4'd6; CDB_Data = 16'h0066;
        tick();
        CDB_Valid = 1'b0;
        chk("t5_valid_early", Issue_Valid, 0);
        tick();
        chk("t5_valid", Issue_Valid, 1);
        chk("t5_oldest_tag", Issue_Tag, 1);
        chk("t5_tag_reserved", Disp_Ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_valid", Issue_Valid, 1);
            chk("t5_hold_tag", Issue_Tag, 1);
            chk("t5_hold_a", Issue_A, 16'h0066);
            chk("t5_hold_b", Issue_B, 16'h0010);
        end
        push_exp(16'h0066, 16'h0010, 3'd4, 4'd1);
        push_exp(16'h0032, 16'h0066, 3'd6, 4'd3);
        Issue_Ready = 1'b1;
        tick();
        chk("t5_second_tag", Issue_Tag, 3);
        tick();
        Issue_Ready = 1'b0;
        chk("t5_empty", Issue_Valid, 0);
        chk("t5_busy_left", Busy_Vec, 4'b1010);
        chk("t5_refill_tag", Disp_Tag, 1);

        // Refill to full with an issue held, then flush.
        CDB_Valid = 1'b1; CDB_Tag = 4'd7; CDB_Data = 16'h0077;
        drive_disp(3'd1, 16'd0, 16'd0, 4'd9, 4'd0);
        tick();
        CDB_Valid = 1'b0;
        drive_disp(3'd2, 16'd0, 16'd0, 4'd9, 4'd0);
        chk("t6_disp_tag", Disp_Tag, 3);
        tick();
        idle_disp();
        chk("t6_valid", Issue_Valid, 1);
        chk("t6_tag", Issue_Tag, 2);
        chk("t6_busy_full", Busy_Vec, 4'b1111);
        chk("t6_disp_ready", Disp_Ready, 0);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("t6_flush_valid", Issue_Valid, 0);
        chk("t6_flush_busy", Busy_Vec, 0);
        chk("t6_flush_ready", Disp_Ready, 1);
        chk("t6_flush_tag", Disp_Tag, 1);
        chk("t6_flush_a", Issue_A, 16'hFFF0);
        tick();
        chk("t6_post_valid", Issue_Valid, 0);

        // Asynchronous reset while an issue is held.
        drive_disp(3'd5, 16'h0055, 16'h0056, 4'd0, 4'd0);
        tick();
        idle_disp();
        tick();
        chk("t1_pre_valid", Issue_Valid, 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("t1_valid", Issue_Valid, 0);
        chk("t1_a", Issue_A, 16'hFFF0);
        chk("t1_busy", Busy_Vec, 0);
        chk("t1_op", Issue_Op, 0);
        chk("t1_tag", Issue_Tag, 0);
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
